// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/load/mem/execute control FSM for the accumulator CPU.
// Holds the instruction register and drives every datapath strobe per state.
module cpu_sequencer #(
    parameter int FETCH_WAIT = 1,
    parameter int MEM_WAIT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [15:0]      instr_in,
    input  logic             serial_busy,
    input  logic             step_mode,
    input  logic             step_pulse,
    output logic [15:0]      ir_out,
    output logic [7:0]       ram_b_addr,
    output logic             pc_inc_en,
    output logic             pc_load_en,
    output logic [7:0]       jump_addr,
    output logic             ram_we,
    output logic             acc_load_en,
    output logic [1:0]       acc_src_sel,
    output logic [3:0]       alu_opcode,
    output logic             alu_b_sel,
    output logic             serial_start,
    output logic             halted,
    output logic [2:0]       state_out,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_LOAD_IR = 3'd1,
        S_MEM     = 3'd2,
        S_EXEC    = 3'd3,
        S_PAUSE   = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    localparam int WMAX = (FETCH_WAIT > MEM_WAIT) ? FETCH_WAIT : MEM_WAIT;
    localparam int WC_W = (WMAX > 1) ? $clog2(WMAX) : 1;
    localparam logic [WC_W-1:0] F_LAST = WC_W'(FETCH_WAIT - 1);
    localparam logic [WC_W-1:0] M_LAST = WC_W'(MEM_WAIT - 1);

    state_t            state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WC_W-1:0]   wait_q, wait_d;
    logic              retire;
    logic [7:0]        op;
    logic [7:0]        nop;

    assign op  = ir_q[15:8];
    assign nop = instr_in[15:8];

    function automatic logic is_mem(input logic [7:0] o);
        return (o == 8'h11) || (o == 8'h31) || (o == 8'h41) || (o == 8'h51);
    endfunction

    function automatic logic is_legal(input logic [7:0] o);
        unique case (o)
            8'h00, 8'h10, 8'h11, 8'h20, 8'h30, 8'h31, 8'h40,
            8'h41, 8'h50, 8'h51, 8'h60, 8'h70, 8'h80: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        cnt_d        = cnt_q;
        wait_d       = wait_q;
        retire       = 1'b0;
        pc_inc_en    = 1'b0;
        pc_load_en   = 1'b0;
        ram_we       = 1'b0;
        acc_load_en  = 1'b0;
        acc_src_sel  = 2'b00;
        alu_opcode   = 4'd0;
        alu_b_sel    = 1'b0;
        serial_start = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (wait_q == F_LAST) begin
                    wait_d  = '0;
                    state_d = S_LOAD_IR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_LOAD_IR: begin
                ir_d      = instr_in;
                pc_inc_en = 1'b1;
                if (is_mem(nop))        state_d = S_MEM;
                else if (is_legal(nop)) state_d = S_EXEC;
                else                    state_d = S_HALT;
            end
            S_MEM: begin
                if (wait_q == M_LAST) begin
                    wait_d  = '0;
                    state_d = S_EXEC;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_EXEC: begin
                retire = 1'b1;
                case (op)
                    8'h10: begin
                        acc_load_en = 1'b1;
                        acc_src_sel = 2'b01;
                    end
                    8'h11: begin
                        acc_load_en = 1'b1;
                        acc_src_sel = 2'b10;
                    end
                    8'h20: ram_we = 1'b1;
                    8'h30, 8'h31, 8'h40, 8'h41, 8'h50, 8'h51: begin
                        acc_load_en = 1'b1;
                        alu_opcode  = {2'b00, op[5:4] - 2'd2};
                        alu_b_sel   = op[0];
                    end
                    8'h60: begin
                        acc_load_en = 1'b1;
                        alu_opcode  = 4'd4;
                    end
                    8'h70: pc_load_en = 1'b1;
                    8'h80: begin
                        // Hold in EXEC until the serial unit can accept the ACC
                        retire       = !serial_busy;
                        serial_start = !serial_busy;
                    end
                    default: ;
                endcase
                if (retire) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = step_mode ? S_PAUSE : S_FETCH;
                end
            end
            S_PAUSE: begin
                if (step_pulse || !step_mode) state_d = S_FETCH;
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase
    end

    assign ir_out      = ir_q;
    assign ram_b_addr  = ir_q[7:0];
    assign jump_addr   = ir_q[7:0];
    assign halted      = (state_q == S_HALT);
    assign state_out   = state_q;
    assign instr_count = cnt_q;

endmodule
